// File: rtl/add12u_err_monitor.sv
// -----------------------------------------------------------------------------
// add12u_err_monitor
//
// Purpose:
//   Error-statistics stage placed after a 12-bit approximate unsigned adder.
//   For every accepted sample (a, b, o_apx) it recomputes the exact sum a+b.
//   It then folds |o_apx - (a+b)| into run-time statistics:
//     - smp_cnt     : number of samples accumulated
//     - err_cnt     : number of samples whose approximate sum was wrong
//     - sum_abs_err : sum of |err|, used for the mean absolute error
//     - max_err     : worst-case |err|
//     - max_a/max_b : operands of the first sample that reached max_err
//     - sum_sq_err  : sum of err^2, used for the mean squared error
//                     (present only with ERRMON_MSE_EN)
//
// Optional feature macro:
//   ERRMON_MSE_EN  when defined, adds the sum_sq_err output and the squaring
//                  datapath. When undefined, both are absent.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   clr          in   synchronous clear back to IDLE; zeroes stats, flushes
//                     the pipeline, and overrides start
//   start        in   one-cycle start pulse; honoured only in IDLE or DONE
//   n_target     in   number of samples to collect; latched on accepted start
//   in_valid     in   a / b / o_apx carry a sample
//   in_ready     out  stage accepts a sample this cycle (state RUN)
//   a, b         in   operands that were given to the adder under test
//   o_apx        in   approximate W+1-bit sum from the adder under test
//   smp_cnt      out  samples accumulated (saturating)
//   err_cnt      out  erroneous samples (saturating)
//   sum_abs_err  out  sum of |err| (saturating)
//   max_err      out  largest |err| seen
//   max_a, max_b out  operands of the first sample that reached max_err
//   sum_sq_err   out  sum of err^2 (saturating; ERRMON_MSE_EN only)
//   busy         out  state is RUN or DRAIN
//   done         out  state is DONE; held until the next start or clr
//   dbg_state    out  raw FSM state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
//
// Handshake:
//   A sample transfers on a rising edge where in_valid and in_ready are both
//   high. The value of in_valid while in_ready is low has no effect.
//   in_ready depends only on the registered state, never on in_valid.
//
// Pipeline:
//   The pipeline has two stages and never stalls.
//   S1 registers the operands, the approximate sum and the exact sum.
//   S2 forms |err| from the S1 registers and updates the statistic registers.
//   A sample that transfers on edge E appears in the statistics after edge E+1.
// -----------------------------------------------------------------------------
module add12u_err_monitor #(
  parameter int W     = 12,
  parameter int CNT_W = 24,
  parameter int ACC_W = W + 1 + CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_target,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [W:0]         o_apx,
  output logic [CNT_W-1:0]   smp_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   sum_abs_err,
  output logic [W:0]         max_err,
  output logic [W-1:0]       max_a,
  output logic [W-1:0]       max_b,
`ifdef ERRMON_MSE_EN
  output logic [2*(W+1)+CNT_W-1:0] sum_sq_err,
`endif
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;     // latched n_target
  logic [CNT_W-1:0]   acc_q, acc_d;     // samples accepted in this run
  logic               drain_q, drain_d; // second DRAIN cycle marker
  logic               stats_clr;        // zero all statistics on this edge
  logic               xfer;
  logic [CNT_W-1:0]   acc_inc;

  assign xfer    = in_valid && (state_q == ST_RUN);
  assign acc_inc = acc_q + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      acc_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      acc_q   <= acc_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    acc_d     = acc_q;
    drain_d   = drain_q;
    stats_clr = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          stats_clr = 1'b1;
          tgt_d     = n_target;
          acc_d     = '0;
          drain_d   = 1'b0;
          // A zero-length run has nothing to collect, so it finishes at once.
          state_d   = (n_target == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          acc_d = acc_inc;
          if (acc_inc == tgt_q) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        // DRAIN lasts exactly two cycles. The first cycle lets the last
        // sample leave S1. The second lets S2 commit that sample.
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d   = ST_IDLE;
      stats_clr = 1'b1;
      tgt_d     = '0;
      acc_d     = '0;
      drain_d   = 1'b0;
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // S1: capture the sample and the exact sum
  // ---------------------------------------------------------------------------
  logic               s1_v_q, s1_v_d;
  logic [W-1:0]       s1_a_q, s1_b_q;
  logic [W:0]         s1_apx_q, s1_exact_q;
  logic [W:0]         exact;

  assign exact  = {1'b0, a} + {1'b0, b};
  assign s1_v_d = xfer && !clr;   // clr discards the sample in flight

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_apx_q   <= '0;
      s1_exact_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      if (xfer) begin
        s1_a_q     <= a;
        s1_b_q     <= b;
        s1_apx_q   <= o_apx;
        s1_exact_q <= exact;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: absolute error and statistics update
  // ---------------------------------------------------------------------------
  logic [W:0]         d;
  logic [ACC_W:0]     sum_abs_ext;
  logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0]   sum_abs_q, sum_abs_d;
  logic [W:0]         max_err_q, max_err_d;
  logic [W-1:0]       max_a_q, max_a_d;
  logic [W-1:0]       max_b_q, max_b_d;

  // Both sums are compared as full W+1-bit unsigned values, so the larger one
  // is always the minuend and the subtraction cannot underflow.
  assign d = (s1_apx_q >= s1_exact_q) ? (s1_apx_q - s1_exact_q)
                                      : (s1_exact_q - s1_apx_q);

  // The extra top bit is the carry-out that drives saturation.
  assign sum_abs_ext = {1'b0, sum_abs_q} + {{(ACC_W-W){1'b0}}, d};

`ifdef ERRMON_MSE_EN
  localparam int SQ_W = 2*(W+1) + CNT_W;
  logic [2*(W+1)-1:0] sq;
  logic [SQ_W:0]      sum_sq_ext;
  logic [SQ_W-1:0]    sum_sq_q, sum_sq_d;

  assign sq         = {{(W+1){1'b0}}, d} * {{(W+1){1'b0}}, d};
  assign sum_sq_ext = {1'b0, sum_sq_q} + {{(CNT_W+1){1'b0}}, sq};
`endif

  always_comb begin
    smp_cnt_d = smp_cnt_q;
    err_cnt_d = err_cnt_q;
    sum_abs_d = sum_abs_q;
    max_err_d = max_err_q;
    max_a_d   = max_a_q;
    max_b_d   = max_b_q;
`ifdef ERRMON_MSE_EN
    sum_sq_d  = sum_sq_q;
`endif
    if (stats_clr) begin
      smp_cnt_d = '0;
      err_cnt_d = '0;
      sum_abs_d = '0;
      max_err_d = '0;
      max_a_d   = '0;
      max_b_d   = '0;
`ifdef ERRMON_MSE_EN
      sum_sq_d  = '0;
`endif
    end else if (s1_v_q) begin
      // Counters and accumulators stick at all-ones instead of wrapping.
      if (smp_cnt_q != '1) begin
        smp_cnt_d = smp_cnt_q + CNT_ONE;
      end
      if ((d != '0) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end
      sum_abs_d = sum_abs_ext[ACC_W] ? '1 : sum_abs_ext[ACC_W-1:0];
      // The comparison is strict, so a tie keeps the earliest sample.
      if (d > max_err_q) begin
        max_err_d = d;
        max_a_d   = s1_a_q;
        max_b_d   = s1_b_q;
      end
`ifdef ERRMON_MSE_EN
      sum_sq_d = sum_sq_ext[SQ_W] ? '1 : sum_sq_ext[SQ_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt_q <= '0;
      err_cnt_q <= '0;
      sum_abs_q <= '0;
      max_err_q <= '0;
      max_a_q   <= '0;
      max_b_q   <= '0;
    end else begin
      smp_cnt_q <= smp_cnt_d;
      err_cnt_q <= err_cnt_d;
      sum_abs_q <= sum_abs_d;
      max_err_q <= max_err_d;
      max_a_q   <= max_a_d;
      max_b_q   <= max_b_d;
    end
  end

`ifdef ERRMON_MSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_sq_q <= '0;
    end else begin
      sum_sq_q <= sum_sq_d;
    end
  end
  assign sum_sq_err = sum_sq_q;
`endif

  assign smp_cnt     = smp_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign sum_abs_err = sum_abs_q;
  assign max_err     = max_err_q;
  assign max_a       = max_a_q;
  assign max_b       = max_b_q;

endmodule

// File: tb/tb_add12u_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_add12u_err_monitor
//
// Bench for add12u_err_monitor.
//   - Stimulus tasks push the expected end-of-run statistics into exp_q.
//   - The monitor process pops exp_q and compares each time done rises.
//   - The expected statistics come from a reference model that works
//     directly on the list of samples offered in a run.
// -----------------------------------------------------------------------------
module tb_add12u_err_monitor;

  localparam int W     = 12;
  localparam int CNT_W = 24;
  localparam int ACC_W = W + 1 + CNT_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clr = 1'b0;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   n_target = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W-1:0]       a = '0;
  logic [W-1:0]       b = '0;
  logic [W:0]         o_apx = '0;
  logic [CNT_W-1:0]   smp_cnt, err_cnt;
  logic [ACC_W-1:0]   sum_abs_err;
  logic [W:0]         max_err;
  logic [W-1:0]       max_a, max_b;
`ifdef ERRMON_MSE_EN
  logic [2*(W+1)+CNT_W-1:0] sum_sq_err;
`endif
  logic               busy, done;
  logic [1:0]         dbg_state;

  add12u_err_monitor dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .n_target(n_target),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .o_apx(o_apx),
    .smp_cnt(smp_cnt), .err_cnt(err_cnt), .sum_abs_err(sum_abs_err),
    .max_err(max_err), .max_a(max_a), .max_b(max_b),
`ifdef ERRMON_MSE_EN
    .sum_sq_err(sum_sq_err),
`endif
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    longint smp, err, sum, mx, ma, mb, sq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_a[$], m_b[$], m_o[$];   // samples of the current run

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: statistics computed from the sample list with ints.
  function automatic exp_t model();
    exp_t e;
    e = '{default: 0};
    e.smp = m_a.size();
    foreach (m_a[i]) begin
      int ex;
      int dd;
      ex = m_a[i] + m_b[i];
      dd = (m_o[i] > ex) ? m_o[i] - ex : ex - m_o[i];
      if (dd != 0) e.err++;
      e.sum += dd;
      e.sq  += longint'(dd) * dd;
      if (dd > e.mx) begin
        e.mx = dd;
        e.ma = m_a[i];
        e.mb = m_b[i];
      end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done rose with no run expected (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("smp_cnt",     smp_cnt,     e.smp);
          chk("err_cnt",     err_cnt,     e.err);
          chk("sum_abs_err", sum_abs_err, e.sum);
          chk("max_err",     max_err,     e.mx);
          chk("max_a",       max_a,       e.ma);
          chk("max_b",       max_b,       e.mb);
`ifdef ERRMON_MSE_EN
          chk("sum_sq_err",  sum_sq_err,  e.sq);
`endif
        end
      end
      done_prev = done;
    end
  end

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  task automatic add_s(input int sa, input int sb, input int so);
    m_a.push_back(sa);
    m_b.push_back(sb);
    m_o.push_back(so);
  endtask

  task automatic clear_model();
    m_a.delete();
    m_b.delete();
    m_o.delete();
  endtask

  task automatic do_start(input int n);
    start    = 1'b1;
    n_target = CNT_W'(n);
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic send(input int sa, input int sb, input int so, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) @(negedge clk);
    a        = W'(sa);
    b        = W'(sb);
    o_apx    = (W+1)'(so);
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("done_timeout", done, 1);
  endtask

  // Runs the samples held in m_a/m_b/m_o. Optionally pulses a start mid-run,
  // which the design must ignore.
  task automatic run_queue(input bit poke_start);
    exp_t e;
    int   n;
    n = m_a.size();
    e = model();
    exp_q.push_back(e);
    do_start(n);
    foreach (m_a[i]) begin
      send(m_a[i], m_b[i], m_o[i], int'($urandom_range(0, 2)));
      if (poke_start && i == 0) do_start(int'($urandom_range(1, 9)));
    end
    wait_done();
    repeat (2) @(negedge clk);
    chk("stable_in_done_smp", smp_cnt, e.smp);
    chk("stable_in_done_sum", sum_abs_err, e.sum);
  endtask

  task automatic gen_random(input int n);
    clear_model();
    for (int i = 0; i < n; i++) begin
      int ra, rb, ex, ro;
      ra = int'($urandom_range(0, 4095));
      rb = int'($urandom_range(0, 4095));
      ex = ra + rb;
      case ($urandom_range(0, 3))
        0:       ro = ex;
        1:       ro = (ex + int'($urandom_range(0, 40))) % 8192;
        2:       ro = (ex + 8192 - int'($urandom_range(0, 40))) % 8192;
        default: ro = int'($urandom_range(0, 8191));
      endcase
      add_s(ra, rb, ro);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int xfers, t2;
    exp_t e;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_smp_cnt", smp_cnt, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-RUN, applied between clock edges.
    clear_model();
    do_start(5);
    send(10, 20, 33, 0);
    @(negedge clk);
    chk("mid_run_smp_cnt", smp_cnt, 1);
    chk("mid_run_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_state", dbg_state, 0);
    chk("async_rst_smp_cnt", smp_cnt, 0);
    chk("async_rst_sum", sum_abs_err, 0);
    chk("async_rst_max_err", max_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Exact-sum samples, including the largest operands.
    clear_model();
    add_s(100, 200, 300);
    add_s(4095, 4095, 8190);
    add_s(1, 1, 2);
    run_queue(1'b0);

    // Errors in both directions, with a tie for the largest error.
    clear_model();
    add_s(100, 200, 290);
    add_s(10, 10, 30);
    add_s(0, 0, 0);
    add_s(7, 8, 5);
    run_queue(1'b0);

    // in_valid held high with n_target = 2.
    clear_model();
    do_start(2);
    in_valid = 1'b1;
    xfers    = 0;
    t2       = -1;
    for (int k = 0; k < 10; k++) begin
      int ra, rb, ro;
      ra    = int'($urandom_range(0, 4095));
      rb    = int'($urandom_range(0, 4095));
      ro    = int'($urandom_range(0, 8191));
      a     = W'(ra);
      b     = W'(rb);
      o_apx = (W+1)'(ro);
      if (t2 >= 0 && k == t2 + 1) chk("hold_in_ready_low", in_ready, 0);
      if (t2 >= 0 && k == t2 + 2) chk("hold_done_not_yet", done, 0);
      if (t2 >= 0 && k == t2 + 3) chk("hold_done_at_3", done, 1);
      if (in_ready) begin
        xfers++;
        add_s(ra, rb, ro);
        if (xfers == 2) begin
          t2 = k;
          e  = model();
          exp_q.push_back(e);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("hold_transfer_count", xfers, 2);

    // n_target = 0 from IDLE: done on the next cycle with all stats zero.
    do_clr();
    chk("clr_done_low", done, 0);
    clear_model();
    e = model();
    exp_q.push_back(e);
    do_start(0);
    chk("n0_done_next_cycle", done, 1);

    // clr while samples are in flight.
    clear_model();
    do_start(5);
    send(50, 60, 100, 0);
    send(70, 80, 200, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_state_idle", dbg_state, 0);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_smp_cnt", smp_cnt, 0);
    chk("clr_sum", sum_abs_err, 0);
    repeat (3) @(negedge clk);
    chk("clr_flushed_smp_cnt", smp_cnt, 0);
    chk("clr_flushed_max_err", max_err, 0);

    // Random runs. A start pulse during RUN must be ignored.
    for (int r = 0; r < 8; r++) begin
      gen_random((r == 0) ? 1 : int'($urandom_range(2, 14)));
      run_queue(r == 3);
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
